// File: rtl/signal_sync_multi.sv
// Multi-channel synchroniser with a per-channel consecutive-sample glitch filter.
// Define SIGNAL_SYNC_MULTI_EDGE_EN to build the registered rise/fall pulse outputs.
module signal_sync_multi #(
    parameter int                CH_NUM      = 8,
    parameter int                SYNC_STAGES = 3,
    parameter int                FILTER_CNT  = 1,
    parameter logic [CH_NUM-1:0] RST_VAL     = {CH_NUM{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] iv_signal_async,
    output logic [CH_NUM-1:0] ov_signal_sync,
    output logic [CH_NUM-1:0] ov_rise_pulse,
    output logic [CH_NUM-1:0] ov_fall_pulse
);

    localparam int               CNT_W    = $clog2(FILTER_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] sync_d [SYNC_STAGES];
    logic [CH_NUM-1:0] sample;
    logic [CNT_W-1:0]  cnt_q  [CH_NUM];
    logic [CNT_W-1:0]  cnt_d  [CH_NUM];
    logic [CH_NUM-1:0] out_q;
    logic [CH_NUM-1:0] out_d;

    always_comb begin
        sync_d[0] = iv_signal_async;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // The output only flips once the sample has disagreed with it for FILTER_CNT edges in a row.
    always_comb begin
        out_d = out_q;
        for (int c = 0; c < CH_NUM; c++) begin
            cnt_d[c] = '0;
            if (sample[c] != out_q[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    out_d[c] = sample[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q <= RST_VAL;
            for (int c = 0; c < CH_NUM; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            out_q <= out_d;
            for (int c = 0; c < CH_NUM; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign ov_signal_sync = out_q;

`ifdef SIGNAL_SYNC_MULTI_EDGE_EN
    logic [CH_NUM-1:0] rise_q;
    logic [CH_NUM-1:0] rise_d;
    logic [CH_NUM-1:0] fall_q;
    logic [CH_NUM-1:0] fall_d;

    // Pulses are derived from the next output so they line up with the new level.
    always_comb begin
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign ov_rise_pulse = rise_q;
    assign ov_fall_pulse = fall_q;
`else
    assign ov_rise_pulse = '0;
    assign ov_fall_pulse = '0;
`endif

endmodule
